// File: rtl/apb_ral_pkg.sv
// Shared types and AHB encodings for the AHB-Lite to APB3 bridge.
// Pure declarations; no latency or flow control of its own.
package apb_ral_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WDATA  = 3'd1,
      SETUP  = 3'd2,
      ACCESS = 3'd3,
      ERR1   = 3'd4,
      ERR2   = 3'd5
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/apb_ral_timeout_cnt.sv
// Counts ACCESS cycles without pready; expired is combinational in the TIMEOUT-th stalled cycle.
// TIMEOUT = 0 keeps expired low forever, so a stuck slave stalls the bus.
module apb_ral_timeout_cnt #(
   parameter int TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CW-1:0] cnt;

   assign expired = (TIMEOUT != 0) && inc && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/apb_ral_ahb2apb_bridge.sv
// AHB-Lite slave to APB3 master: one APB SETUP/ACCESS per single-word AHB transfer.
// Read completes with 2 wait states, write with 3 (pready=1); hreadyout is low until APB finishes.
module apb_ral_ahb2apb_bridge
   import apb_ral_pkg::*;
#(
   parameter int HADDR_W = 32,
   parameter int PADDR_W = 16,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic               hclk,
   input  logic               hresetn,
   input  logic               hsel,
   input  logic [HADDR_W-1:0] haddr,
   input  logic [1:0]         htrans,
   input  logic               hwrite,
   input  logic [2:0]         hsize,
   input  logic [DATA_W-1:0]  hwdata,
   input  logic               hready,
   output logic               hreadyout,
   output logic               hresp,
   output logic [DATA_W-1:0]  hrdata,
   output logic               psel,
   output logic               penable,
   output logic               pwrite,
   output logic [PADDR_W-1:0] paddr,
   output logic [DATA_W-1:0]  pwdata,
   input  logic [DATA_W-1:0]  prdata,
   input  logic               pready,
   input  logic               pslverr
);

   state_t state, state_nxt;
   logic   accept;
   logic   expired;
   logic   unused_haddr;

   // Upper address bits are decoded by the fabric, not here.
   assign unused_haddr = ^haddr[HADDR_W-1:PADDR_W];

   assign accept = (state == IDLE) && hsel && hready &&
                   ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

   // Handshake outputs decode straight from the state register so reset clears them at once.
   assign hreadyout = (state == IDLE) || (state == ERR2);
   assign hresp     = (state == ERR1) || (state == ERR2);
   assign psel      = (state == SETUP) || (state == ACCESS);
   assign penable   = (state == ACCESS);

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (hsize != HSIZE_WORD) state_nxt = ERR1;
               else if (hwrite)         state_nxt = WDATA;
               else                     state_nxt = SETUP;
            end
         end
         WDATA:  state_nxt = SETUP;
         SETUP:  state_nxt = ACCESS;
         ACCESS: begin
            if (pready)       state_nxt = pslverr ? ERR1 : IDLE;
            else if (expired) state_nxt = ERR1;
         end
         ERR1:    state_nxt = ERR2;
         ERR2:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         paddr  <= '0;
         pwrite <= 1'b0;
         pwdata <= '0;
         hrdata <= '0;
      end else begin
         if (accept) begin
            paddr  <= haddr[PADDR_W-1:0];
            pwrite <= hwrite;
         end
         if (state == WDATA) begin
            pwdata <= hwdata;
         end
         if ((state == ACCESS) && pready && !pslverr && !pwrite) begin
            hrdata <= prdata;
         end
      end
   end

   apb_ral_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (hclk),
      .rst_n   (hresetn),
      .clr     (state_nxt == SETUP),
      .inc     ((state == ACCESS) && !pready),
      .expired (expired)
   );

endmodule

// File: tb/tb_apb_ral_ahb2apb_bridge.sv
// Directed bench for the AHB-to-APB bridge, with a small APB memory target behind it.
module tb_apb_ral_ahb2apb_bridge;

   logic        hclk;
   logic        hresetn;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   logic        slv_ready;
   logic        slv_err;
   logic [31:0] mem [0:127];
   logic [6:0]  mem_idx;

   int tests = 0;
   int fails = 0;
   int pen_cycles;

   apb_ral_ahb2apb_bridge #(
      .HADDR_W (32),
      .PADDR_W (16),
      .DATA_W  (32),
      .TIMEOUT (4)
   ) dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .hsel      (hsel),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hwdata    (hwdata),
      .hready    (hready),
      .hreadyout (hreadyout),
      .hresp     (hresp),
      .hrdata    (hrdata),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // APB target: word memory covering the RAM low words and the two registers.
   assign mem_idx = {paddr[12], paddr[7:2]};
   assign prdata  = mem[mem_idx];
   assign pready  = slv_ready;
   assign pslverr = slv_err;

   always @(posedge hclk) begin
      if (psel && penable && pready && pwrite && !pslverr) mem[mem_idx] <= pwdata;
   end

   task automatic tick;
      @(posedge hclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
      hsel   = 1'b1;
      htrans = 2'b10;
      haddr  = a;
      hwrite = w;
      hsize  = sz;
   endtask

   task automatic bus_idle;
      hsel   = 1'b0;
      htrans = 2'b00;
      hwrite = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      hresetn   = 1'b0;
      hsel      = 1'b0;
      haddr     = 32'h0;
      htrans    = 2'b00;
      hwrite    = 1'b0;
      hsize     = 3'b010;
      hwdata    = 32'h0;
      hready    = 1'b1;
      slv_ready = 1'b1;
      slv_err   = 1'b0;

      repeat (2) @(posedge hclk);
      #1;
      check("rst_hreadyout", hreadyout, 1);
      check("rst_hresp",     hresp,     0);
      check("rst_hrdata",    hrdata,    0);
      check("rst_psel",      psel,      0);
      check("rst_penable",   penable,   0);
      check("rst_pwrite",    pwrite,    0);
      check("rst_paddr",     paddr,     0);
      check("rst_pwdata",    pwdata,    0);
      hresetn = 1'b1;
      tick;

      // Not selected, and selected with hready low: nothing happens.
      addr_phase(32'h1000, 1'b1, 3'b010);
      hsel = 1'b0;
      tick;
      check("nosel_psel",   psel,      0);
      check("nosel_hready", hreadyout, 1);
      hsel   = 1'b1;
      hready = 1'b0;
      tick;
      check("hrdy0_psel",   psel,      0);
      check("hrdy0_hready", hreadyout, 1);
      hready = 1'b1;
      bus_idle;
      tick;

      // Register write 0x1000 = 5, then read it back.
      addr_phase(32'h1000, 1'b1, 3'b010);
      tick;
      check("wr_t1_hreadyout", hreadyout, 0);
      check("wr_t1_psel",      psel,      0);
      hwdata = 32'h0000_0005;
      bus_idle;
      tick;
      check("wr_t2_psel",    psel,    1);
      check("wr_t2_penable", penable, 0);
      check("wr_t2_pwrite",  pwrite,  1);
      check("wr_t2_paddr",   paddr,   16'h1000);
      tick;
      check("wr_t3_penable", penable, 1);
      check("wr_t3_pwdata",  pwdata,  32'h0000_0005);
      check("wr_t3_paddr",   paddr,   16'h1000);
      tick;
      check("wr_t4_hreadyout", hreadyout, 1);
      check("wr_t4_psel",      psel,      0);
      addr_phase(32'h1000, 1'b0, 3'b010);
      tick;
      check("rd_t1_psel",   psel,   1);
      check("rd_t1_pwrite", pwrite, 0);
      bus_idle;
      tick;
      check("rd_t2_penable",   penable,   1);
      check("rd_t2_hreadyout", hreadyout, 0);
      tick;
      check("rd_t3_hreadyout", hreadyout, 1);
      check("rd_t3_hrdata",    hrdata,    32'h0000_0005);
      check("rd_t3_hresp",     hresp,     0);

      // RAM write then back-to-back read with no idle bubble.
      addr_phase(32'h0000_0010, 1'b1, 3'b010);
      tick;
      hwdata = 32'hDEAD_BEEF;
      bus_idle;
      tick;
      tick;
      tick;
      check("b2b_wr_done", hreadyout, 1);
      addr_phase(32'h0000_0010, 1'b0, 3'b010);
      tick;
      check("b2b_no_bubble", psel,  1);
      check("b2b_paddr",     paddr, 16'h0010);
      bus_idle;
      tick;
      tick;
      check("b2b_hrdata",    hrdata,    32'hDEAD_BEEF);
      check("b2b_hreadyout", hreadyout, 1);

      // Slave error on a register read.
      slv_err = 1'b1;
      addr_phase(32'h1004, 1'b0, 3'b010);
      tick;
      bus_idle;
      tick;
      check("slverr_access", penable, 1);
      tick;
      slv_err = 1'b0;
      check("slverr_e1_hresp",  hresp,     1);
      check("slverr_e1_hrdy",   hreadyout, 0);
      check("slverr_e1_psel",   psel,      0);
      tick;
      check("slverr_e2_hresp",  hresp,     1);
      check("slverr_e2_hrdy",   hreadyout, 1);
      tick;
      check("slverr_idle_hresp", hresp,     0);
      check("slverr_hrdata",     hrdata,    32'hDEAD_BEEF);

      // Non-word size: error response without APB activity.
      addr_phase(32'h0000_0020, 1'b1, 3'b000);
      tick;
      check("hsize_e1_psel",  psel,      0);
      check("hsize_e1_hresp", hresp,     1);
      check("hsize_e1_hrdy",  hreadyout, 0);
      bus_idle;
      tick;
      check("hsize_e2_psel",  psel,      0);
      check("hsize_e2_hresp", hresp,     1);
      check("hsize_e2_hrdy",  hreadyout, 1);
      tick;
      check("hsize_idle_hresp", hresp, 0);
      check("hsize_mem",        mem[8], 32'h0);

      // Timeout with TIMEOUT=4: four ACCESS cycles, then abort.
      slv_ready = 1'b0;
      hsize     = 3'b010;
      addr_phase(32'h0000_0030, 1'b0, 3'b010);
      tick;
      bus_idle;
      pen_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (penable) pen_cycles++;
         else break;
      end
      check("tmo_pen_cycles", pen_cycles, 4);
      check("tmo_e1_psel",    psel,       0);
      check("tmo_e1_hresp",   hresp,      1);
      check("tmo_e1_hrdy",    hreadyout,  0);
      tick;
      check("tmo_e2_hresp",   hresp,      1);
      check("tmo_e2_hrdy",    hreadyout,  1);
      tick;
      check("tmo_idle_hresp", hresp,      0);

      // Reset in the middle of ACCESS.
      addr_phase(32'h0000_0040, 1'b0, 3'b010);
      tick;
      bus_idle;
      tick;
      check("rstmid_access", penable, 1);
      #2;
      hresetn = 1'b0;
      #1;
      check("rstmid_psel",    psel,      0);
      check("rstmid_penable", penable,   0);
      check("rstmid_hrdy",    hreadyout, 1);
      check("rstmid_hresp",   hresp,     0);
      #2;
      hresetn   = 1'b1;
      slv_ready = 1'b1;
      tick;
      addr_phase(32'h0000_0044, 1'b1, 3'b010);
      tick;
      hwdata = 32'h1234_5678;
      bus_idle;
      tick;
      tick;
      tick;
      addr_phase(32'h0000_0044, 1'b0, 3'b010);
      tick;
      bus_idle;
      tick;
      tick;
      check("post_rst_hrdata", hrdata,    32'h1234_5678);
      check("post_rst_hrdy",   hreadyout, 1);
      check("post_rst_hresp",  hresp,     0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
